// File: rtl/game_defs.sv
// Shared definitions for the sprite-game input stage.
//   rpt_state_t : per-switch auto-repeat FSM encoding.
//   SW_*        : bit positions of the direction switches within the Switch bus.
//   cnt_w       : width of a counter that must hold 0..max_val (never narrower than 1 bit).
package game_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  localparam int SW_LEFT  = 0;
  localparam int SW_RIGHT = 1;
  localparam int SW_DOWN  = 2;
  localparam int SW_UP    = 3;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/switch_channel.sv
// One switch lane: 2-flop synchroniser, debounce filter and auto-repeat FSM.
//   CLK_12MHz : sole clock
//   Reset_n   : synchronous active-low reset
//   sw        : raw board switch, asynchronous, active-low
//   tick      : shared one-cycle repeat tick from the top-level prescaler
//   pressed   : debounced level, active-high
//   step      : registered one-cycle movement strobe
module switch_channel
  import game_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int REPEAT_DELAY    = 32
) (
  input  logic CLK_12MHz,
  input  logic Reset_n,
  input  logic sw,
  input  logic tick,
  output logic pressed,
  output logic step
);

  localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam int DL_W = cnt_w(REPEAT_DELAY);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DL_W-1:0] DL_INIT = DL_W'(REPEAT_DELAY);
  localparam logic [DL_W-1:0] DL_ONE  = DL_W'(1);

  logic            sync_p0;
  logic            sync_p1;
  logic            raw_p;
  logic [DB_W-1:0] db_cnt;
  logic            pressed_nxt;
  rpt_state_t      state;
  rpt_state_t      state_nxt;
  logic [DL_W-1:0] dcnt;
  logic [DL_W-1:0] dcnt_nxt;
  logic            step_nxt;

  // Stage p0/p1: synchroniser, resets to the released (high) level
  always_ff @(posedge CLK_12MHz) begin
    if (!Reset_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

  assign raw_p = ~sync_p1;

  // Debounce stage: the counter must sit at DB_MAX for one more mismatching
  // sample before the level is accepted, giving DEBOUNCE_CYCLES+2 clocks of
  // latency from the first sampling edge.
  always_comb begin
    pressed_nxt = pressed;
    if ((raw_p != pressed) && (db_cnt == DB_MAX)) pressed_nxt = raw_p;
  end

  always_ff @(posedge CLK_12MHz) begin
    if (!Reset_n) begin
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else begin
      pressed <= pressed_nxt;
      if ((raw_p == pressed) || (db_cnt == DB_MAX)) db_cnt <= '0;
      else                                         db_cnt <= db_cnt + 1'b1;
    end
  end

  // Repeat stage: release is taken from pressed_nxt so that no strobe can
  // appear on or after the edge where the debounced level falls. The press
  // strobe uses the registered level, landing one clock after Pressed rises.
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    step_nxt  = 1'b0;
    if (!pressed_nxt) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pressed) begin
            step_nxt = 1'b1;
            if (REPEAT_DELAY == 0) begin
              state_nxt = ST_REPEAT;
            end else begin
              state_nxt = ST_DELAY;
              dcnt_nxt  = DL_INIT;
            end
          end
        end
        ST_DELAY: begin
          if (tick) begin
            if (dcnt <= DL_ONE) state_nxt = ST_REPEAT;
            else                dcnt_nxt  = dcnt - 1'b1;
          end
        end
        ST_REPEAT: begin
          // Guard keeps strobes apart when a tick directly follows the press
          if (tick && !step) step_nxt = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_12MHz) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      dcnt  <= '0;
      step  <= 1'b0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      step  <= step_nxt;
    end
  end

endmodule

// File: rtl/switch_conditioner.sv
// Upstream input stage of the sprite game: synchronises and debounces the
// active-low board switches and produces per-switch Step strobes (press plus
// auto-repeat) as plain enables on the single system clock.
//   CLK_12MHz : sole clock
//   Reset_n   : synchronous active-low reset
//   Switch    : raw switches, asynchronous, active-low (0 = pressed)
//   Pressed   : debounced level per switch, active-high
//   Step      : one-cycle movement strobe per switch
//   Tick      : one-cycle pulse every STEP_DIV clocks
// DEBOUNCE_CYCLES must be >= 1 and STEP_DIV must be >= 2.
module switch_conditioner
  import game_defs::*;
#(
  parameter int NUM_SW          = 6,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int STEP_DIV        = 65536,
  parameter int REPEAT_DELAY    = 32
) (
  input  logic              CLK_12MHz,
  input  logic              Reset_n,
  input  logic [NUM_SW-1:0] Switch,
  output logic [NUM_SW-1:0] Pressed,
  output logic [NUM_SW-1:0] Step,
  output logic              Tick
);

  localparam int TK_W = cnt_w(STEP_DIV - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(STEP_DIV - 1);

  logic [TK_W-1:0] tk_cnt;

  // Prescaler stage: Tick is registered one count early so it is high
  // exactly while tk_cnt holds STEP_DIV-1.
  always_ff @(posedge CLK_12MHz) begin
    if (!Reset_n) begin
      tk_cnt <= '0;
      Tick   <= 1'b0;
    end else begin
      tk_cnt <= (tk_cnt == TK_LAST) ? '0 : tk_cnt + 1'b1;
      Tick   <= (tk_cnt == TK_LAST - 1'b1);
    end
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_ch
    switch_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY)
    ) u_ch (
      .CLK_12MHz(CLK_12MHz),
      .Reset_n  (Reset_n),
      .sw       (Switch[i]),
      .tick     (Tick),
      .pressed  (Pressed[i]),
      .step     (Step[i])
    );
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner with DEBOUNCE_CYCLES=4, STEP_DIV=8, REPEAT_DELAY=2.
// Expected Step events are scheduled from the stimulus into a queue and
// popped as the cycle they are due is reached.
module tb_switch_conditioner;
  import game_defs::*;

  localparam int NSW = 6;
  localparam int DB  = 4;
  localparam int DIV = 8;
  localparam int RD  = 2;

  logic           CLK_12MHz = 1'b0;
  logic           Reset_n;
  logic [NSW-1:0] Switch;
  logic [NSW-1:0] Pressed;
  logic [NSW-1:0] Step;
  logic           Tick;

  switch_conditioner #(
    .NUM_SW(NSW), .DEBOUNCE_CYCLES(DB), .STEP_DIV(DIV), .REPEAT_DELAY(RD)
  ) dut (
    .CLK_12MHz(CLK_12MHz),
    .Reset_n  (Reset_n),
    .Switch   (Switch),
    .Pressed  (Pressed),
    .Step     (Step),
    .Tick     (Tick)
  );

  always #5 CLK_12MHz = ~CLK_12MHz;

  int cyc = 0;
  always @(posedge CLK_12MHz) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_err  = 0;
  int r_edge = 0;

  typedef struct {
    int             cyc;
    logic [NSW-1:0] m;
  } ev_t;
  ev_t exp_q[$];

  // Tick is visible in the cycle after edges r+7, r+15, ... (r = last reset edge)
  function automatic bit is_tick(input int t, input int r);
    return (t > r) && (((t - r) % DIV) == DIV - 1);
  endfunction

  // Schedule Steps for a press first sampled at edge c0; nothing at or after lim
  function automatic void predict(input int c0, input int lim, input int r, input logic [NSW-1:0] m);
    int  p;
    int  ticks;
    ev_t e;
    p     = c0 + DB + 2;
    ticks = 0;
    e.m   = m;
    if (p + 1 < lim) begin
      e.cyc = p + 1;
      exp_q.push_back(e);
    end
    for (int t = p + 1; t + 1 < lim; t++) begin
      if (is_tick(t, r)) begin
        ticks++;
        if (ticks > RD) begin
          e.cyc = t + 1;
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  task automatic test_reset();
    Reset_n = 1'b0;
    Switch  = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK_12MHz);
      n_vec++;
      if ({Pressed, Step, Tick} !== 13'b0) begin
        n_err++;
        $display("FAIL reset cyc=%0d got P=%b S=%b T=%b want all 0", cyc, Pressed, Step, Tick);
      end
    end
    r_edge  = cyc;
    Reset_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge CLK_12MHz);
      n_vec++;
      if ({Pressed, Step, Tick} !== {12'b0, is_tick(cyc, r_edge)}) begin
        n_err++;
        $display("FAIL reset_tick cyc=%0d got P=%b S=%b T=%b want T=%b", cyc, Pressed, Step, Tick, is_tick(cyc, r_edge));
      end
    end
  endtask

  task automatic test_clean_press();
    int s, p, f;
    ev_t ev;
    logic [NSW-1:0] m, es, ep;
    m = NSW'(1) << SW_LEFT;
    @(negedge CLK_12MHz);
    s = cyc;
    p = s + 1 + DB + 2;
    f = s + 41 + DB + 2;
    predict(s + 1, f, r_edge, m);
    for (int k = 0; k < 56; k++) begin
      if (k == 0)  Switch[SW_LEFT] = 1'b0;
      if (k == 40) Switch[SW_LEFT] = 1'b1;
      @(negedge CLK_12MHz);
      es = '0;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin ev = exp_q.pop_front(); es = ev.m; end
      ep = (cyc >= p && cyc < f) ? m : '0;
      n_vec++;
      if ({Pressed, Step, Tick} !== {ep, es, is_tick(cyc, r_edge)}) begin
        n_err++;
        $display("FAIL clean_press cyc=%0d got P=%b S=%b T=%b want P=%b S=%b T=%b", cyc, Pressed, Step, Tick, ep, es, is_tick(cyc, r_edge));
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL clean_press_missing got %0d unseen steps want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_bounce();
    int s, p, f;
    ev_t ev;
    logic [NSW-1:0] m, es, ep;
    m = NSW'(1) << SW_RIGHT;
    @(negedge CLK_12MHz);
    s = cyc;
    p = s + 6 + DB + 2;
    f = s + 46 + DB + 2;
    predict(s + 6, f, r_edge, m);
    for (int k = 0; k < 62; k++) begin
      if (k == 0)  Switch[SW_RIGHT] = 1'b0;
      if (k == 3)  Switch[SW_RIGHT] = 1'b1;
      if (k == 5)  Switch[SW_RIGHT] = 1'b0;
      if (k == 45) Switch[SW_RIGHT] = 1'b1;
      @(negedge CLK_12MHz);
      es = '0;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin ev = exp_q.pop_front(); es = ev.m; end
      ep = (cyc >= p && cyc < f) ? m : '0;
      n_vec++;
      if ({Pressed, Step, Tick} !== {ep, es, is_tick(cyc, r_edge)}) begin
        n_err++;
        $display("FAIL bounce cyc=%0d got P=%b S=%b T=%b want P=%b S=%b T=%b", cyc, Pressed, Step, Tick, ep, es, is_tick(cyc, r_edge));
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bounce_missing got %0d unseen steps want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Release is timed so Pressed falls on the very edge that would carry a
  // repeat Step; a second press afterwards must give a fresh press Step.
  task automatic test_release_mid_repeat();
    int s, p, f, t, k_rel, k2, c2, p2, f2, n;
    ev_t ev;
    logic [NSW-1:0] m, es, ep;
    m = NSW'(1) << SW_DOWN;
    @(negedge CLK_12MHz);
    s = cyc;
    p = s + 1 + DB + 2;
    t = s + 40;
    while (!is_tick(t, r_edge)) t++;
    f     = t + 1;
    k_rel = f - DB - 2 - s - 1;
    k2    = k_rel + 10;
    c2    = s + k2 + 1;
    p2    = c2 + DB + 2;
    f2    = c2 + 12 + DB + 2;
    n     = k2 + 25;
    predict(s + 1, f, r_edge, m);
    predict(c2, f2, r_edge, m);
    for (int k = 0; k < n; k++) begin
      if (k == 0)       Switch[SW_DOWN] = 1'b0;
      if (k == k_rel)   Switch[SW_DOWN] = 1'b1;
      if (k == k2)      Switch[SW_DOWN] = 1'b0;
      if (k == k2 + 12) Switch[SW_DOWN] = 1'b1;
      @(negedge CLK_12MHz);
      es = '0;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin ev = exp_q.pop_front(); es = ev.m; end
      ep = ((cyc >= p && cyc < f) || (cyc >= p2 && cyc < f2)) ? m : '0;
      n_vec++;
      if ({Pressed, Step, Tick} !== {ep, es, is_tick(cyc, r_edge)}) begin
        n_err++;
        $display("FAIL release cyc=%0d got P=%b S=%b T=%b want P=%b S=%b T=%b", cyc, Pressed, Step, Tick, ep, es, is_tick(cyc, r_edge));
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL release_missing got %0d unseen steps want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    int s, p, f;
    ev_t ev;
    logic [NSW-1:0] m, es, ep;
    m = (NSW'(1) << SW_LEFT) | (NSW'(1) << SW_UP);
    @(negedge CLK_12MHz);
    s = cyc;
    p = s + 1 + DB + 2;
    f = s + 41 + DB + 2;
    predict(s + 1, f, r_edge, m);
    for (int k = 0; k < 56; k++) begin
      if (k == 0)  begin Switch[SW_LEFT] = 1'b0; Switch[SW_UP] = 1'b0; end
      if (k == 40) begin Switch[SW_LEFT] = 1'b1; Switch[SW_UP] = 1'b1; end
      @(negedge CLK_12MHz);
      es = '0;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin ev = exp_q.pop_front(); es = ev.m; end
      ep = (cyc >= p && cyc < f) ? m : '0;
      n_vec++;
      if ({Pressed, Step, Tick} !== {ep, es, is_tick(cyc, r_edge)}) begin
        n_err++;
        $display("FAIL simultaneous cyc=%0d got P=%b S=%b T=%b want P=%b S=%b T=%b", cyc, Pressed, Step, Tick, ep, es, is_tick(cyc, r_edge));
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL simultaneous_missing got %0d unseen steps want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_repeat();
    int s, p, r_old, r_new, p2, f2;
    bit et;
    ev_t ev;
    logic [NSW-1:0] m, es, ep;
    m = NSW'(1) << SW_LEFT;
    @(negedge CLK_12MHz);
    s     = cyc;
    r_old = r_edge;
    r_new = s + 37;
    p     = s + 1 + DB + 2;
    p2    = r_new + 1 + DB + 2;
    f2    = s + 58 + DB + 2;
    predict(s + 1, r_new, r_old, m);
    predict(r_new + 1, f2, r_new, m);
    for (int k = 0; k < 70; k++) begin
      if (k == 0)  Switch[SW_LEFT] = 1'b0;
      if (k == 36) Reset_n = 1'b0;
      if (k == 37) Reset_n = 1'b1;
      if (k == 57) Switch[SW_LEFT] = 1'b1;
      @(negedge CLK_12MHz);
      if (cyc >= r_new) r_edge = r_new;
      et = is_tick(cyc, r_edge);
      es = '0;
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin ev = exp_q.pop_front(); es = ev.m; end
      ep = ((cyc >= p && cyc < r_new) || (cyc >= p2 && cyc < f2)) ? m : '0;
      n_vec++;
      if ({Pressed, Step, Tick} !== {ep, es, et}) begin
        n_err++;
        $display("FAIL reset_mid cyc=%0d got P=%b S=%b T=%b want P=%b S=%b T=%b", cyc, Pressed, Step, Tick, ep, es, et);
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_missing got %0d unseen steps want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_mid_repeat();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no completion want finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
